// File: rtl/rv32_pkg.sv
// Shared RV32 memory-access encodings, FSM states and strobe patterns for the
// memory stage and its alignment helper.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 values follow this core's own encoding, not the base ISA.
    localparam logic [2:0] F3_SW  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SB  = 3'b010;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    function automatic acc_size_e acc_size(input logic is_store, input logic [2:0] funct3);
        acc_size_e sz;
        if (is_store) begin
            case (funct3)
                F3_SB:   sz = SZ_B;
                F3_SH:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            // LBU/LHU share the size bits of LB/LH
            case (funct3[1:0])
                2'b00:   sz = SZ_B;
                2'b01:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replication and misalignment on the
// incoming slot, load byte/half extraction and extension on the returned word.
module mem_align
    import rv32_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    acc_size_e   size;
    logic [31:0] shifted;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        size       = acc_size(is_store, funct3);
        misaligned = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
        case (size)
            SZ_B: begin
                wstrb = WSTRB_B << off;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                wstrb = WSTRB_H << off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wstrb = WSTRB_W;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        ld_b    = shifted[7:0];
        ld_h    = shifted[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
            F3_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
            F3_LBU:  ld_data = {24'd0, ld_b};
            F3_LHU:  ld_data = {16'd0, ld_h};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory accesses over a req/gnt/rvalid bus,
// stalls execute while busy and retires one registered result per slot.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode_exe_2_mem_i,
    input  logic [4:0]  rd_exe_2_mem_i,
    input  logic [31:0] rd_data_exe_2_mem_i,
    input  logic [31:0] men_data_i,
    input  logic        load_valid_i,
    input  logic        store_valid_i,
    output logic        mem_stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_wstrb_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [10:0] opcode_mem_2_wb_o,
    output logic [4:0]  rd_mem_2_wb_o,
    output logic [31:0] rd_data_mem_2_wb_o,
    output logic        wb_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    mem_state_e  state;
    logic [10:0] op_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_store_q;
    logic [7:0]  tcnt;

    logic [7:0]  tcnt_nxt;
    logic        timeout_hit;
    logic        is_mem;
    logic        al_misaligned;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;

    mem_align u_align (
        .is_store   (store_valid_i),
        .funct3     (opcode_exe_2_mem_i[9:7]),
        .off        (rd_data_exe_2_mem_i[1:0]),
        .st_data    (men_data_i),
        .misaligned (al_misaligned),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (dmem_rdata_i),
        .ld_data    (al_ld_data)
    );

    assign is_mem      = load_valid_i | store_valid_i;
    assign mem_stall_o = (state != ST_IDLE);
    assign tcnt_nxt    = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
    assign timeout_hit = (tcnt_nxt >= TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            op_q               <= '0;
            rd_q               <= '0;
            f3_q               <= '0;
            off_q              <= '0;
            is_store_q         <= 1'b0;
            tcnt               <= '0;
            dmem_req_o         <= 1'b0;
            dmem_we_o          <= 1'b0;
            dmem_addr_o        <= '0;
            dmem_wstrb_o       <= '0;
            dmem_wdata_o       <= '0;
            opcode_mem_2_wb_o  <= '0;
            rd_mem_2_wb_o      <= '0;
            rd_data_mem_2_wb_o <= '0;
            wb_valid_o         <= 1'b0;
            misalign_o         <= 1'b0;
            bus_err_o          <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_mem && al_misaligned) begin
                        wb_valid_o         <= 1'b1;
                        misalign_o         <= 1'b1;
                        opcode_mem_2_wb_o  <= opcode_exe_2_mem_i;
                        rd_mem_2_wb_o      <= '0;
                        rd_data_mem_2_wb_o <= '0;
                    end else if (is_mem) begin
                        // store_valid_i takes precedence when both flags are set
                        state        <= ST_REQ;
                        op_q         <= opcode_exe_2_mem_i;
                        rd_q         <= rd_exe_2_mem_i;
                        f3_q         <= opcode_exe_2_mem_i[9:7];
                        off_q        <= rd_data_exe_2_mem_i[1:0];
                        is_store_q   <= store_valid_i;
                        tcnt         <= '0;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= store_valid_i;
                        dmem_addr_o  <= {rd_data_exe_2_mem_i[31:2], 2'b00};
                        dmem_wstrb_o <= store_valid_i ? al_wstrb : 4'b0000;
                        dmem_wdata_o <= store_valid_i ? al_wdata : 32'd0;
                    end else if (opcode_exe_2_mem_i != '0) begin
                        wb_valid_o         <= 1'b1;
                        opcode_mem_2_wb_o  <= opcode_exe_2_mem_i;
                        rd_mem_2_wb_o      <= rd_exe_2_mem_i;
                        rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
                    end
                end

                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_wstrb_o <= '0;
                        tcnt         <= '0;
                        if (is_store_q) begin
                            state              <= ST_IDLE;
                            wb_valid_o         <= 1'b1;
                            opcode_mem_2_wb_o  <= op_q;
                            rd_mem_2_wb_o      <= '0;
                            rd_data_mem_2_wb_o <= '0;
                        end else if (dmem_rvalid_i) begin
                            state              <= ST_IDLE;
                            wb_valid_o         <= 1'b1;
                            opcode_mem_2_wb_o  <= op_q;
                            rd_mem_2_wb_o      <= rd_q;
                            rd_data_mem_2_wb_o <= al_ld_data;
                        end else begin
                            state <= ST_WAIT_R;
                        end
                    end else if (timeout_hit) begin
                        state              <= ST_IDLE;
                        dmem_req_o         <= 1'b0;
                        dmem_we_o          <= 1'b0;
                        dmem_wstrb_o       <= '0;
                        bus_err_o          <= 1'b1;
                        wb_valid_o         <= 1'b1;
                        opcode_mem_2_wb_o  <= op_q;
                        rd_mem_2_wb_o      <= '0;
                        rd_data_mem_2_wb_o <= '0;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                ST_WAIT_R: begin
                    if (dmem_rvalid_i) begin
                        state              <= ST_IDLE;
                        wb_valid_o         <= 1'b1;
                        opcode_mem_2_wb_o  <= op_q;
                        rd_mem_2_wb_o      <= rd_q;
                        rd_data_mem_2_wb_o <= al_ld_data;
                    end else if (timeout_hit) begin
                        state              <= ST_IDLE;
                        bus_err_o          <= 1'b1;
                        wb_valid_o         <= 1'b1;
                        opcode_mem_2_wb_o  <= op_q;
                        rd_mem_2_wb_o      <= '0;
                        rd_data_mem_2_wb_o <= '0;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalignment,
// bus timeout and reset during an outstanding read.
module tb_mem_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opc;
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic [31:0] mdata;
    logic        lv, sv;
    logic        stall;
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic [10:0] wb_op;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_valid, misalign, bus_err;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .opcode_exe_2_mem_i  (opc),
        .rd_exe_2_mem_i      (rd),
        .rd_data_exe_2_mem_i (rdd),
        .men_data_i          (mdata),
        .load_valid_i        (lv),
        .store_valid_i       (sv),
        .mem_stall_o         (stall),
        .dmem_req_o          (req),
        .dmem_we_o           (we),
        .dmem_addr_o         (addr),
        .dmem_wstrb_o        (wstrb),
        .dmem_wdata_o        (wdata),
        .dmem_gnt_i          (gnt),
        .dmem_rvalid_i       (rvalid),
        .dmem_rdata_i        (rdata),
        .opcode_mem_2_wb_o   (wb_op),
        .rd_mem_2_wb_o       (wb_rd),
        .rd_data_mem_2_wb_o  (wb_data),
        .wb_valid_o          (wb_valid),
        .misalign_o          (misalign),
        .bus_err_o           (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        opc = '0; rd = '0; rdd = '0; mdata = '0; lv = 1'b0; sv = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvalid one cycle later.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] r, input logic [31:0] word, input logic [31:0] exp);
        opc = {1'b0, f3, OPC_LOAD}; rd = r; rdd = a; lv = 1'b1;
        tick();
        chk({tag, "_req"}, {31'd0, req}, 32'd1);
        chk({tag, "_addr"}, addr, {a[31:2], 2'b00});
        chk({tag, "_wstrb"}, {28'd0, wstrb}, 32'd0);
        gnt = 1'b1;
        bubble();
        tick();
        chk({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
        chk({tag, "_req_drop"}, {31'd0, req}, 32'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = word;
        tick();
        rvalid = 1'b0;
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, r});
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        tick();
        chk({tag, "_wbv_pulse"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        bubble();
        tick(); tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        rst = 1'b0;

        // ALU result passes through with latency 1
        opc = 11'b0_000_0110011; rd = 5'd5; rdd = 32'h1234;
        tick();
        chk("add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("add_rd", {27'd0, wb_rd}, 32'd5);
        chk("add_data", wb_data, 32'h1234);
        chk("add_op", {21'd0, wb_op}, 32'h033);
        chk("add_stall", {31'd0, stall}, 32'd0);
        bubble();
        tick();
        chk("bubble_wbv", {31'd0, wb_valid}, 32'd0);

        run_load("lb",  F3_LB,  32'h103, 5'd7,  32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lbu", F3_LBU, 32'h103, 5'd7,  32'h80FF_FFFF, 32'h0000_0080);
        run_load("lh",  F3_LH,  32'h102, 5'd8,  32'h8001_1234, 32'hFFFF_8001);
        run_load("lhu", F3_LHU, 32'h100, 5'd9,  32'h1234_8001, 32'h0000_8001);
        run_load("lw",  F3_LW,  32'h10,  5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // SH with grant delayed three cycles
        opc = {1'b0, F3_SH, OPC_STORE}; rd = 5'd9; rdd = 32'h22; mdata = 32'hBEEF; sv = 1'b1;
        tick();
        chk("sh_req0", {31'd0, req}, 32'd1);
        chk("sh_we", {31'd0, we}, 32'd1);
        chk("sh_addr", addr, 32'h20);
        chk("sh_wstrb", {28'd0, wstrb}, 32'hC);
        chk("sh_wdata", wdata, 32'hBEEF_BEEF);
        bubble();
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("sh_req_held", {31'd0, req}, 32'd1);
            chk("sh_stall", {31'd0, stall}, 32'd1);
            chk("sh_wstrb_held", {28'd0, wstrb}, 32'hC);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("sh_req_drop", {31'd0, req}, 32'd0);
        chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sh_rd", {27'd0, wb_rd}, 32'd0);
        chk("sh_stall_done", {31'd0, stall}, 32'd0);

        // SB with load_valid also set: store must win
        opc = {1'b0, F3_SB, OPC_STORE}; rd = 5'd3; rdd = 32'h41; mdata = 32'hA5; sv = 1'b1; lv = 1'b1;
        tick();
        chk("sb_we", {31'd0, we}, 32'd1);
        chk("sb_wstrb", {28'd0, wstrb}, 32'h2);
        chk("sb_wdata", wdata, 32'hA5A5_A5A5);
        chk("sb_addr", addr, 32'h40);
        bubble();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sb_rd", {27'd0, wb_rd}, 32'd0);

        // Misaligned LW: no bus traffic
        opc = {1'b0, F3_LW, OPC_LOAD}; rd = 5'd11; rdd = 32'h6; lv = 1'b1;
        tick();
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("mis_rd", {27'd0, wb_rd}, 32'd0);
        chk("mis_data", wb_data, 32'd0);
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        bubble();
        tick();
        chk("mis_pulse", {31'd0, misalign}, 32'd0);
        chk("mis_req_after", {31'd0, req}, 32'd0);

        // gnt and rvalid together complete the load at once
        opc = {1'b0, F3_LW, OPC_LOAD}; rd = 5'd3; rdd = 32'h10; lv = 1'b1;
        tick();
        bubble();
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        gnt = 1'b0; rvalid = 1'b0;
        chk("gr_wbv", {31'd0, wb_valid}, 32'd1);
        chk("gr_data", wb_data, 32'hCAFE_F00D);
        chk("gr_rd", {27'd0, wb_rd}, 32'd3);
        chk("gr_stall", {31'd0, stall}, 32'd0);

        // Read data never returns: bus error after 16 waiting cycles
        opc = {1'b0, F3_LW, OPC_LOAD}; rd = 5'd4; rdd = 32'h40; lv = 1'b1;
        tick();
        bubble();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_stall_before", {31'd0, stall}, 32'd1);
        chk("tmo_err_before", {31'd0, bus_err}, 32'd0);
        tick();
        chk("tmo_err", {31'd0, bus_err}, 32'd1);
        chk("tmo_wbv", {31'd0, wb_valid}, 32'd1);
        chk("tmo_rd", {27'd0, wb_rd}, 32'd0);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("tmo_pulse", {31'd0, bus_err}, 32'd0);

        // Reset while waiting for read data; late rvalid is ignored
        opc = {1'b0, F3_LW, OPC_LOAD}; rd = 5'd6; rdd = 32'h50; lv = 1'b1;
        tick();
        bubble();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("rw_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'h1111_2222;
        chk("rw_stall_rst", {31'd0, stall}, 32'd0);
        chk("rw_req_rst", {31'd0, req}, 32'd0);
        tick();
        rvalid = 1'b0;
        chk("rw_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rw_wbdata", wb_data, 32'd0);
        chk("rw_rd", {27'd0, wb_rd}, 32'd0);
        chk("rw_stall_after", {31'd0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
